// File: rtl/ssp_pkg.sv
// ssp_pkg: shared state type and configuration helpers for the SSP serialiser
package ssp_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT} ssp_state_t;
  localparam int DATA_W_MIN = 4;
  localparam int DATA_W_MAX = 16;
  function automatic bit cfg_ok(input int data_w, input int clk_div);
    return data_w >= DATA_W_MIN && data_w <= DATA_W_MAX && clk_div >= 2 && clk_div % 2 == 0;
  endfunction
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction
endpackage

// File: rtl/ssp_edge_sync.sv
// ssp_edge_sync: two-flop synchroniser with registered rise/fall pulses
module ssp_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      q <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s0 <= d;
      q <= s0;
      rise <= s0 & ~q;
      fall <= ~s0 & q;
    end
  end
endmodule

// File: rtl/ssp_serdes.sv
// ssp_serdes: TI-SSI style SSP serialiser/deserialiser with master divider and slave mode
module ssp_serdes import ssp_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              MASTER,
  input  logic              SSPCLKIN,
  input  logic              SSPFSSIN,
  input  logic              SSPRXD,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxValid,
  output logic              TxReady,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  input  logic              RxReady,
  output logic              SSPCLKOUT,
  output logic              SSPFSSOUT,
  output logic              SSPTXD,
  output logic              SSPOE_B,
  output logic              SSPTXINTR,
  output logic              SSPRXINTR
);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = cnt_w(DATA_W);
  if (!cfg_ok(DATA_W, CLK_DIV)) begin : g_cfg_err
    $error("ssp_serdes: DATA_W must be 4..16 and CLK_DIV even and >= 2");
  end
  ssp_state_t state;
  logic [DW-1:0] div, div_nxt;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] tx_sh, rx_word;
  logic [DATA_W-2:0] rx_sh;
  logic mode, is_master, done, cont, rise, fall;
  logic sclk_rise, sclk_fall, sfss, sclk_unused;
  logic [1:0] fss_edges_unused;
  ssp_edge_sync u_clk_sync (
    .clk(PCLK), .rst_n(CLEAR_B), .d(SSPCLKIN),
    .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  ssp_edge_sync u_fss_sync (
    .clk(PCLK), .rst_n(CLEAR_B), .d(SSPFSSIN),
    .q(sfss), .rise(fss_edges_unused[1]), .fall(fss_edges_unused[0])
  );
  always_comb begin
    div_nxt = (div == DW'(CLK_DIV - 1)) ? '0 : div + 1'b1;
    is_master = (state == IDLE) ? MASTER : mode;
    rise = is_master ? (div == DW'(CLK_DIV - 1)) : sclk_rise;
    fall = is_master ? (div == DW'(HALF - 1)) : sclk_fall;
    rx_word = {rx_sh, SSPRXD};
  end
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      mode <= 1'b0;
      done <= 1'b0;
      cont <= 1'b0;
      SSPCLKOUT <= 1'b0;
      SSPFSSOUT <= 1'b0;
      SSPTXD <= 1'b0;
      SSPOE_B <= 1'b1;
      TxReady <= 1'b0;
      RxValid <= 1'b0;
      RxData <= '0;
      SSPTXINTR <= 1'b0;
      SSPRXINTR <= 1'b0;
    end else begin
      div <= div_nxt;
      SSPCLKOUT <= is_master && div_nxt < DW'(HALF);
      TxReady <= 1'b0;
      RxValid <= 1'b0;
      SSPTXINTR <= 1'b0;
      SSPRXINTR <= 1'b0;
      if (state == IDLE) mode <= MASTER;
      case (state)
        IDLE: begin
          if (is_master && rise && TxValid) begin
            state <= SYNC;
            SSPFSSOUT <= 1'b1;
            TxReady <= 1'b1;
            tx_sh <= TxData;
          end else if (!is_master && fall && sfss) begin
            state <= SYNC;
            TxReady <= TxValid;
            SSPTXINTR <= !TxValid;
            tx_sh <= TxValid ? TxData : '0;
          end
        end
        SYNC: begin
          if (rise) begin
            state <= SHIFT;
            SSPFSSOUT <= 1'b0;
            SSPOE_B <= 1'b0;
            SSPTXD <= tx_sh[DATA_W-1];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            bit_cnt <= CW'(DATA_W - 1);
            done <= 1'b0;
            cont <= 1'b0;
          end
        end
        default: begin
          if (rise && done) begin
            done <= 1'b0;
            cont <= 1'b0;
            SSPFSSOUT <= 1'b0;
            if (cont) begin
              SSPTXD <= tx_sh[DATA_W-1];
              tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
              bit_cnt <= CW'(DATA_W - 1);
            end else begin
              state <= IDLE;
              SSPOE_B <= 1'b1;
              SSPTXD <= 1'b0;
            end
          end else if (rise) begin
            SSPTXD <= tx_sh[DATA_W-1];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            // LSB launch: the next word is popped now so its MSB follows with no gap
            if (is_master && bit_cnt == '0 && TxValid) begin
              tx_sh <= TxData;
              TxReady <= 1'b1;
              SSPFSSOUT <= 1'b1;
              cont <= 1'b1;
            end
          end
          if (fall && !done) begin
            rx_sh <= rx_word[DATA_W-2:0];
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == '0) begin
              done <= 1'b1;
              RxValid <= RxReady;
              SSPRXINTR <= !RxReady;
              if (RxReady) RxData <= rx_word;
              if (!is_master && sfss) begin
                cont <= 1'b1;
                TxReady <= TxValid;
                SSPTXINTR <= !TxValid;
                tx_sh <= TxValid ? TxData : '0;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ssp_serdes.md
# ssp_serdes

Parametrised next-generation serialiser/deserialiser core for the synchronous serial port (SSP), sitting between the TX/RX FIFOs and the SSP pins. It supports word widths other than 8 bits, a programmable master clock divider and a runtime master/slave select. It sends back-to-back frames without idle gaps and reports TX underrun and RX overrun. Framing is TI-SSI style:

- One-SSPCLK frame pulse precedes the MSB.
- Data launches on the SSPCLK rising edge and is sampled on the falling edge.

## Interface
Parameters:
- DATA_W, 8: word width in bits; legal range 4..16.
- CLK_DIV, 2: master SSPCLKOUT period in PCLK cycles; must be even and ≥2.

Ports:
- PCLK  in  1  the block's only clock; all logic on rising edge.
- CLEAR_B  in  1  asynchronous active-low reset.
- MASTER  in  1  1 = master (drives clock and frame), 0 = slave; change only while idle.
- SSPCLKIN, SSPFSSIN, SSPRXD  in  1  slave clock, slave frame, and serial receive data.
- TxData  in  DATA_W  head word of the TX FIFO.
- TxValid  in  1  TX FIFO non-empty.
- TxReady  out  1  one-cycle pop strobe; TxData is captured in that cycle.
- RxData  out  DATA_W  last received word; held until the next word.
- RxValid  out  1  one-cycle push strobe to the RX FIFO.
- RxReady  in  1  RX FIFO not full.
- SSPCLKOUT, SSPFSSOUT, SSPTXD  out  1  master clock, frame pulse and serial transmit data.
- SSPOE_B  out  1  active-low TXD output enable.
- SSPTXINTR  out  1  one-cycle pulse on TX underrun.
- SSPRXINTR  out  1  one-cycle pulse on RX overrun.

## Operation
- Reset values: SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, TxReady=0, RxValid=0, RxData=0, SSPTXINTR=0, SSPRXINTR=0. Divider and bit counter are 0; FSM is IDLE.
- Reset asserted mid-frame aborts the frame immediately; no partial word is pushed.
- Master clock: divider count runs 0..CLK_DIV-1 continuously.
  - SSPCLKOUT=1 for count < CLK_DIV/2.
  - The "rise" event occurs on wrap to 0; the "fall" event occurs at count CLK_DIV/2.
- Slave clock: SSPCLKIN and SSPFSSIN are 2-flop synchronised. Rise/fall events come from edge detection of the synchronised clock.
- FSM states: IDLE, SYNC, SHIFT.
  - IDLE→SYNC, master: rise event with TxValid=1. FSS=1 for one SSPCLK period and TxReady pulses once.
  - IDLE→SYNC, slave: SSPFSSIN sampled high on a fall event. TxReady pulses if TxValid=1; otherwise the shift register loads 0 and SSPTXINTR pulses.
  - SYNC→SHIFT: next rise event. The MSB goes on SSPTXD, SSPOE_B=0 and the bit counter is set to DATA_W-1.
  - SHIFT: each rise event shifts the next bit out MSB-first; each fall event shifts SSPRXD in. The bit counter decrements on the fall event.
  - Back-to-back, master: at the rise starting the LSB, if TxValid=1 the next word loads and FSS is asserted during the LSB. The next MSB follows immediately, with no idle gap.
  - Back-to-back, slave: SSPFSSIN sampled high during the LSB behaves the same way.
  - End of frame: with no continuation, SHIFT→IDLE on the rise after the LSB. SSPOE_B=1 and SSPTXD=0.
- Receive completion, on the fall event sampling the LSB:
  - RxReady=1: RxData updates and RxValid pulses.
  - RxReady=0: the word is dropped, RxData is unchanged and SSPRXINTR pulses.
- Master never underruns; it waits in IDLE for TxValid.
- The MASTER input is only sampled while in IDLE.

## Timing
- Master, CLK_DIV=2, DATA_W=8: one frame every 9 SSPCLK periods (18 PCLK) when isolated; back-to-back frames repeat every 8 periods (16 PCLK).
- Master latency:
  - TxValid high to first FSS: at most CLK_DIV PCLK cycles.
  - FSS high to MSB on pin: CLK_DIV PCLK cycles.
- RxValid asserts 1 PCLK cycle after the LSB fall event.
- Slave outputs lag the SSPCLKIN edge by 3 PCLK cycles (2 sync + 1 register).
- Slave input requirement: SSPCLKIN high and low phases each ≥4 PCLK cycles.
- TxReady, RxValid and both interrupt outputs are single-PCLK pulses. They never assert in the same cycle as reset deassertion.

## Structure
- Package ssp_pkg holds:
  - the state enum {IDLE, SYNC, SHIFT};
  - elaboration checks for DATA_W range and CLK_DIV even/≥2;
  - the bit-counter width, $clog2(DATA_W).
- Sub-module ssp_edge_sync: 2-flop synchroniser plus registered rise/fall pulse outputs. Instantiated for SSPCLKIN and SSPFSSIN.
- Top level contains the divider, FSM, TX/RX shift registers and bit counter.

## Test plan
- Master single word: DATA_W=8, CLK_DIV=2, TxData=0xA5 presented once.
  - One TxReady pulse; SSPTXD carries 1,0,1,0,0,1,0,1 on successive rises after a one-period FSS.
  - Loopback TXD→RXD gives RxData=0xA5 with a single RxValid.
- Master back-to-back: 0x3C then 0xC3 with TxValid held high.
  - FSS asserted during the first LSB; no idle period between words.
  - Two RxValid pulses exactly 16 PCLK apart.
- Width/divider sweep: DATA_W=12, CLK_DIV=6, TxData=0x9F1.
  - SSPCLKOUT period is 6 PCLK; the frame spans 13 SSPCLK periods; looped-back RxData=0x9F1.
- Slave mode: SSPCLKIN period 10 PCLK, frame pulse, bits of 0x5A driven on SSPRXD, TxValid=0.
  - RxData=0x5A; SSPTXINTR pulses once; SSPTXD shifts zeros.
- Overrun and reset: RxReady=0 at frame end gives one SSPRXINTR pulse and RxData unchanged.
  - CLEAR_B pulsed low mid-SHIFT: all outputs return to their reset values asynchronously.
  - No RxValid follows; the next frame completes normally.
